// File: rtl/mcu_gpio_pkg.sv
// mcu_gpio_pkg: register map and limits
// shared by the apb_gpio_v2 peripheral.
package mcu_gpio_pkg;

    localparam int GPIO_MAX_PINS = 32;

    typedef enum logic [3:0] {
        REG_DIR      = 4'h0,
        REG_IN       = 4'h1,
        REG_OUT      = 4'h2,
        REG_OUT_SET  = 4'h3,
        REG_OUT_CLR  = 4'h4,
        REG_INT_EN   = 4'h5,
        REG_INT_LVL  = 4'h6,
        REG_INT_POL  = 4'h7,
        REG_INT_BOTH = 4'h8,
        REG_INT_STAT = 4'h9
    } gpio_reg_e;

    function automatic logic reg_mapped(input logic [3:0] idx);
        return idx <= REG_INT_STAT;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: pad synchroniser plus one cycle
// of history for rise/fall detection.
module gpio_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] in_s,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  in_q;

    // shift pads through the chain, keep last synced value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            in_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
            in_q   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_s = sync_q[SYNC_STAGES-1];
    assign rise = in_s & ~in_q;
    assign fall = ~in_s & in_q;

endmodule

// File: rtl/apb_gpio_v2.sv
// apb_gpio_v2: APB GPIO with atomic set/clear
// and per-pin edge/level interrupts.
module apb_gpio_v2
    import mcu_gpio_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_GPIO       = 32,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_GPIO-1:0]       gpio_in,
    output logic [NUM_GPIO-1:0]       gpio_out,
    output logic [NUM_GPIO-1:0]       gpio_dir,
    output logic                      interrupt
);

    logic [3:0]               idx;
    logic                     access;
    logic                     mapped;
    logic                     wr_en;
    logic [NUM_GPIO-1:0]      wdata;
    logic [NUM_GPIO-1:0]      dir_q;
    logic [NUM_GPIO-1:0]      out_q;
    logic [NUM_GPIO-1:0]      en_q;
    logic [NUM_GPIO-1:0]      lvl_q;
    logic [NUM_GPIO-1:0]      pol_q;
    logic [NUM_GPIO-1:0]      both_q;
    logic [NUM_GPIO-1:0]      stat_q;
    logic                     irq_q;
    logic [NUM_GPIO-1:0]      in_s;
    logic [NUM_GPIO-1:0]      rise;
    logic [NUM_GPIO-1:0]      fall;
    logic [NUM_GPIO-1:0]      edge_ev;
    logic [NUM_GPIO-1:0]      set;
    logic [NUM_GPIO-1:0]      w1c;
    logic [GPIO_MAX_PINS-1:0] rdata;
    logic                     unused_bits;

    assign idx         = PADDR[5:2];
    assign access      = PSEL & PENABLE;
    assign mapped      = reg_mapped(idx);
    assign wr_en       = access & PWRITE & mapped;
    assign wdata       = PWDATA[NUM_GPIO-1:0];
    assign unused_bits = ^{PADDR, PWDATA};

    gpio_sync_edge #(
        .WIDTH       (NUM_GPIO),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pad    (gpio_in),
        .in_s   (in_s),
        .rise   (rise),
        .fall   (fall)
    );

    // commit APB writes to config and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q  <= '0;
            out_q  <= '0;
            en_q   <= '0;
            lvl_q  <= '0;
            pol_q  <= '0;
            both_q <= '0;
        end else if (wr_en) begin
            unique case (1'b1)
                (idx == REG_DIR):      dir_q  <= wdata;
                (idx == REG_OUT):      out_q  <= wdata;
                (idx == REG_OUT_SET):  out_q  <= out_q | wdata;
                (idx == REG_OUT_CLR):  out_q  <= out_q & ~wdata;
                (idx == REG_INT_EN):   en_q   <= wdata;
                (idx == REG_INT_LVL):  lvl_q  <= wdata;
                (idx == REG_INT_POL):  pol_q  <= wdata;
                (idx == REG_INT_BOTH): both_q <= wdata;
                default: ;
            endcase
        end
    end

    // per-pin event: level compare or the selected edge(s)
    always_comb begin
        edge_ev = (both_q & (rise | fall))
                | (~both_q & pol_q & rise)
                | (~both_q & ~pol_q & fall);
        set     = (lvl_q & ~(in_s ^ pol_q)) | (~lvl_q & edge_ev);
        w1c     = '0;
        if (wr_en && idx == REG_INT_STAT) begin
            w1c = wdata;
        end
    end

    // sticky status, a coincident event beats its clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= (stat_q & ~w1c) | set;
            irq_q  <= |(stat_q & en_q);
        end
    end

    // read mux, unmapped and write-only offsets read 0
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (idx == REG_DIR):      rdata = 32'(dir_q);
            (idx == REG_IN):       rdata = 32'(in_s);
            (idx == REG_OUT):      rdata = 32'(out_q);
            (idx == REG_INT_EN):   rdata = 32'(en_q);
            (idx == REG_INT_LVL):  rdata = 32'(lvl_q);
            (idx == REG_INT_POL):  rdata = 32'(pol_q);
            (idx == REG_INT_BOTH): rdata = 32'(both_q);
            (idx == REG_INT_STAT): rdata = 32'(stat_q);
            default:               rdata = '0;
        endcase
    end

    assign PRDATA    = (access && mapped) ? rdata : '0;
    assign PSLVERR   = access & ~mapped;
    assign PREADY    = 1'b1;
    assign gpio_out  = out_q;
    assign gpio_dir  = dir_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_apb_gpio_v2.sv
// tb_apb_gpio_v2: table vectors, directed corner
// sequences and random traffic against a pin model.
module tb_apb_gpio_v2;

    localparam int NG   = 8;
    localparam int SYNC = 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [11:0]   PADDR   = '0;
    logic [31:0]   PWDATA  = '0;
    logic          PWRITE  = 1'b0;
    logic          PSEL    = 1'b0;
    logic          PENABLE = 1'b0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [NG-1:0] gpio_in = '0;
    logic [NG-1:0] gpio_out;
    logic [NG-1:0] gpio_dir;
    logic          interrupt;

    int total = 0;
    int bad   = 0;

    apb_gpio_v2 #(
        .APB_ADDR_WIDTH (12),
        .NUM_GPIO       (NG),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_dir  (gpio_dir),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NG-1:0] m_dir = '0, m_out = '0, m_en = '0;
    logic [NG-1:0] m_lvl = '0, m_pol = '0, m_both = '0;
    logic [NG-1:0] m_stat = '0;
    logic          m_irq = 1'b0;
    logic [NG-1:0] hist[$];
    logic [NG-1:0] ev, clr, s_now, s_old, wd;

    // hist[0] is the previous synced value, hist[1] the current one
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dir = '0; m_out = '0; m_en = '0;
            m_lvl = '0; m_pol = '0; m_both = '0;
            m_stat = '0; m_irq = 1'b0;
            hist.delete();
            repeat (SYNC + 1) hist.push_back('0);
        end else begin
            s_now = hist[1];
            s_old = hist[0];
            for (int i = 0; i < NG; i++) begin
                if (m_lvl[i])
                    ev[i] = (s_now[i] == m_pol[i]);
                else if (m_both[i])
                    ev[i] = (s_now[i] != s_old[i]);
                else if (m_pol[i])
                    ev[i] = s_now[i] && !s_old[i];
                else
                    ev[i] = !s_now[i] && s_old[i];
            end
            m_irq = |(m_stat & m_en);
            clr = '0;
            wd = PWDATA[NG-1:0];
            if (PSEL && PENABLE && PWRITE) begin
                case ({PADDR[5:2], 2'b00})
                    6'h00: m_dir  = wd;
                    6'h08: m_out  = wd;
                    6'h0C: m_out  = m_out | wd;
                    6'h10: m_out  = m_out & ~wd;
                    6'h14: m_en   = wd;
                    6'h18: m_lvl  = wd;
                    6'h1C: m_pol  = wd;
                    6'h20: m_both = wd;
                    6'h24: clr    = wd;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clr) | ev;
            hist.push_back(gpio_in);
            void'(hist.pop_front());
        end
    end

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        case ({a[5:2], 2'b00})
            6'h00: return 32'(m_dir);
            6'h04: return 32'(hist[1]);
            6'h08: return 32'(m_out);
            6'h14: return 32'(m_en);
            6'h18: return 32'(m_lvl);
            6'h1C: return 32'(m_pol);
            6'h20: return 32'(m_both);
            6'h24: return 32'(m_stat);
            default: return 32'h0;
        endcase
    endfunction

    // continuous output check against the model
    always @(negedge clk) begin
        chk("mon_out", 32'(gpio_out), 32'(m_out));
        chk("mon_dir", 32'(gpio_dir), 32'(m_dir));
        chk("mon_irq", 32'(interrupt), 32'(m_irq));
        chk("mon_ready", 32'(PREADY), 32'h1);
    end

    // ---------------- APB helpers ----------------
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = a; PWDATA = d;
        @(posedge clk); #1 PENABLE = 1'b1;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d,
                            output logic e, output logic [31:0] md);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge clk); #1 PENABLE = 1'b1;
        #1 d = PRDATA; e = PSLVERR; md = model_rd(a);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [11:0] a,
                          input logic [31:0] exp);
        logic [31:0] d, md;
        logic e;
        apb_read(a, d, e, md);
        chk(n, d, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [11:0] wa;
        logic [31:0] wd;
        logic [11:0] ra;
        logic [31:0] rexp;
        logic        rerr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, md;
        logic e;
        logic [11:0] a;
        int op;

        tbl[0]  = '{12'h000, 32'h0000FFFF, 12'h000, 32'hFF, 1'b0};
        tbl[1]  = '{12'h008, 32'h000000F0, 12'h008, 32'hF0, 1'b0};
        tbl[2]  = '{12'h00C, 32'h0000000F, 12'h008, 32'hFF, 1'b0};
        tbl[3]  = '{12'h010, 32'h00000030, 12'h008, 32'hCF, 1'b0};
        tbl[4]  = '{12'h00C, 32'h00000100, 12'h00C, 32'h00, 1'b0};
        tbl[5]  = '{12'h010, 32'h00000000, 12'h008, 32'hCF, 1'b0};
        tbl[6]  = '{12'h004, 32'h000000FF, 12'h004, 32'h00, 1'b0};
        tbl[7]  = '{12'h014, 32'h00001234, 12'h014, 32'h34, 1'b0};
        tbl[8]  = '{12'h01C, 32'h000000A5, 12'h01C, 32'hA5, 1'b0};
        tbl[9]  = '{12'h020, 32'h0000000F, 12'h020, 32'h0F, 1'b0};
        tbl[10] = '{12'h028, 32'hFFFFFFFF, 12'h028, 32'h00, 1'b1};
        tbl[11] = '{12'h03C, 32'h00000000, 12'h000, 32'hFF, 1'b0};
        tbl[12] = '{12'h408, 32'h0000003C, 12'h008, 32'h3C, 1'b0};
        tbl[13] = '{12'h024, 32'h000000FF, 12'h024, 32'h00, 1'b0};
        tbl[14] = '{12'h018, 32'h00000000, 12'h03C, 32'h00, 1'b1};
        tbl[15] = '{12'h010, 32'h000000FF, 12'h010, 32'h00, 1'b0};

        // 1: reset with toggling pads
        repeat (5) begin
            @(posedge clk); #1 gpio_in = NG'($urandom);
            @(negedge clk);
            chk("rst_out", 32'(gpio_out), 32'h0);
            chk("rst_dir", 32'(gpio_dir), 32'h0);
            chk("rst_irq", 32'(interrupt), 32'h0);
            chk("rst_err", 32'(PSLVERR), 32'h0);
        end
        @(posedge clk); #1 gpio_in = '0; rst_n = 1'b1;
        rd_chk("rst_stat", 12'h024, 32'h0);

        // register table
        foreach (tbl[i]) begin
            apb_write(tbl[i].wa, tbl[i].wd);
            apb_read(tbl[i].ra, d, e, md);
            chk($sformatf("tbl%0d_rd", i), d, tbl[i].rexp);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].rerr));
        end
        do_reset();

        // 2: OUT / OUT_SET / OUT_CLR, one cycle each
        apb_write(12'h008, 32'hF0);
        @(negedge clk); chk("t2_out_f0", 32'(gpio_out), 32'hF0);
        apb_write(12'h00C, 32'h0F);
        @(negedge clk); chk("t2_out_ff", 32'(gpio_out), 32'hFF);
        apb_write(12'h010, 32'h30);
        @(negedge clk); chk("t2_out_cf", 32'(gpio_out), 32'hCF);
        rd_chk("t2_rd_out", 12'h008, 32'hCF);

        // 3: rising edge on pin 3, latency of the interrupt
        apb_write(12'h014, 32'h08);
        apb_write(12'h01C, 32'h08);
        @(posedge clk); #1 gpio_in[3] = 1'b1;
        @(posedge clk); @(negedge clk); chk("t3_irq_c1", 32'(interrupt), 32'h0);
        @(posedge clk); @(negedge clk); chk("t3_irq_c2", 32'(interrupt), 32'h0);
        @(posedge clk); @(negedge clk); chk("t3_irq_c3", 32'(interrupt), 32'h0);
        @(posedge clk); @(negedge clk); chk("t3_irq_c4", 32'(interrupt), 32'h1);
        rd_chk("t3_stat", 12'h024, 32'h08);
        rd_chk("t3_in", 12'h004, 32'h08);
        apb_write(12'h024, 32'h08);
        @(negedge clk); chk("t3_irq_w0", 32'(interrupt), 32'h1);
        @(posedge clk); @(negedge clk); chk("t3_irq_w1", 32'(interrupt), 32'h0);
        rd_chk("t3_stat_clr", 12'h024, 32'h0);

        // 4: level-low on pin 5 re-sets after W1C
        apb_write(12'h01C, 32'h00);
        apb_write(12'h018, 32'h20);
        apb_write(12'h024, 32'h20);
        rd_chk("t4_stat_held", 12'h024, 32'h20);
        @(posedge clk); #1 gpio_in[5] = 1'b1;
        repeat (4) @(posedge clk);
        #1 rd_chk("t4_stat_sticky", 12'h024, 32'h20);
        apb_write(12'h024, 32'h20);
        rd_chk("t4_stat_gone", 12'h024, 32'h0);

        // 5: both edges on pin 0, then edge vs W1C
        apb_write(12'h018, 32'h00);
        apb_write(12'h014, 32'h01);
        apb_write(12'h020, 32'h01);
        apb_write(12'h024, 32'hFF);
        rd_chk("t5_stat0", 12'h024, 32'h0);
        @(posedge clk); #1 gpio_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 12'h024; PWDATA = 32'h01;
        @(posedge clk); #1 gpio_in[0] = 1'b0; PENABLE = 1'b1;
        @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge clk); chk("t5_irq_rise", 32'(interrupt), 32'h1);
        @(posedge clk); @(negedge clk); chk("t5_irq_clr", 32'(interrupt), 32'h0);
        @(posedge clk); @(negedge clk); chk("t5_irq_gap", 32'(interrupt), 32'h0);
        @(posedge clk); @(negedge clk); chk("t5_irq_fall", 32'(interrupt), 32'h1);
        apb_write(12'h024, 32'h01);
        rd_chk("t5_stat_clr", 12'h024, 32'h0);
        @(posedge clk); #1 gpio_in[0] = 1'b1;
        @(posedge clk); #1 apb_write(12'h024, 32'h01);
        rd_chk("t5_set_wins", 12'h024, 32'h01);

        // 6: reset in the middle of an access phase
        apb_write(12'h008, 32'hAA);
        apb_write(12'h000, 32'h55);
        gpio_in = '0;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h008;
        PWDATA = 32'h11; PENABLE = 1'b0;
        @(posedge clk); #1 PENABLE = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_out", 32'(gpio_out), 32'h0);
        chk("t6_dir", 32'(gpio_dir), 32'h0);
        chk("t6_irq", 32'(interrupt), 32'h0);
        chk("t6_prdata", PRDATA, 32'h0);
        @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        rd_chk("t6_rd_out", 12'h008, 32'h0);
        rd_chk("t6_rd_dir", 12'h000, 32'h0);
        rd_chk("t6_rd_en", 12'h014, 32'h0);
        rd_chk("t6_rd_stat", 12'h024, 32'h0);

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0)
                gpio_in = gpio_in ^ NG'($urandom);
            op = int'($urandom_range(0, 9));
            a = {6'($urandom), 4'($urandom_range(0, 11)), 2'($urandom)};
            if (op < 4) begin
                apb_write(a, $urandom);
            end else if (op < 8) begin
                apb_read(a, d, e, md);
                chk("rnd_rd", d, md);
                chk("rnd_err", 32'(e), 32'(a[5:2] > 4'd9));
            end else begin
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
